// File: rtl/if_fetch_if.sv
// Bundle of the fetch unit's redirect, instruction-memory and decode-side
// handshake signals. master = fetch unit, slave = its environment.
interface if_fetch_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        inst_ready_i;

  modport master (
    input  jump_en_i, jump_addr_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    output imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o
  );

  modport slave (
    output jump_en_i, jump_addr_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    input  imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC, issues pipelined reads limited by a
// credit count (in-flight + buffered <= FIFO_DEPTH), buffers {addr,data} in a
// prefetch FIFO and hands one instruction per handshake to decode. A redirect
// flushes the FIFO and marks every still-in-flight response for discard.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input logic        clk,
  input logic        rst,
  if_fetch_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PONE_C  = PW'(1);
  localparam logic [PW-1:0] PZERO_C = PW'(0);

  logic [31:0]   fetch_pc_r, resp_pc_r;
  logic [CW-1:0] outstanding_r, discard_r, count_r;
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [31:0]   addr_mem_r [FIFO_DEPTH];
  logic [31:0]   data_mem_r [FIFO_DEPTH];

  logic [31:0]   fetch_pc_nxt_s, resp_pc_nxt_s, target_s;
  logic [CW-1:0] outstanding_nxt_s, discard_nxt_s, count_nxt_s;
  logic [PW-1:0] rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [CW:0]   credit_s;
  logic          req_s, issue_s, valid_s, pop_s, drop_s, push_s;

  // Redirect target is word aligned: low two bits are cleared.
  assign target_s = bus.jump_addr_i & 32'hFFFF_FFFC;
  assign credit_s = {1'b0, outstanding_r} + {1'b0, count_r};
  // Request only when a FIFO slot is reserved for the response; held low in reset.
  assign req_s    = !rst && !bus.jump_en_i && (credit_s < DEPTH_C);
  assign issue_s  = req_s && bus.imem_gnt_i;
  assign valid_s  = (count_r != ZERO_C) && !bus.jump_en_i;
  assign pop_s    = valid_s && bus.inst_ready_i;
  // A response is stale if it belongs to a pre-redirect request.
  assign drop_s   = bus.imem_rvalid_i && ((discard_r != ZERO_C) || bus.jump_en_i);
  assign push_s   = bus.imem_rvalid_i && !drop_s;

  // Next-state computation for PCs, counters and FIFO pointers
  always_comb begin
    fetch_pc_nxt_s    = fetch_pc_r;
    resp_pc_nxt_s     = resp_pc_r;
    discard_nxt_s     = discard_r;
    count_nxt_s       = count_r;
    rd_ptr_nxt_s      = rd_ptr_r;
    wr_ptr_nxt_s      = wr_ptr_r;
    outstanding_nxt_s = outstanding_r;

    case ({issue_s, bus.imem_rvalid_i})
      2'b10:   outstanding_nxt_s = outstanding_r + ONE_C;
      2'b01:   outstanding_nxt_s = outstanding_r - ONE_C;
      default: outstanding_nxt_s = outstanding_r;
    endcase

    if (bus.jump_en_i) begin
      fetch_pc_nxt_s = target_s;
      resp_pc_nxt_s  = target_s;
      discard_nxt_s  = outstanding_r - (bus.imem_rvalid_i ? ONE_C : ZERO_C);
      count_nxt_s    = ZERO_C;
      rd_ptr_nxt_s   = PZERO_C;
      wr_ptr_nxt_s   = PZERO_C;
    end else begin
      if (issue_s) begin
        fetch_pc_nxt_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (push_s) begin
        resp_pc_nxt_s = resp_pc_r + 32'd4;
        wr_ptr_nxt_s  = wr_ptr_r + PONE_C;
      end else begin
        resp_pc_nxt_s = resp_pc_r;
        wr_ptr_nxt_s  = wr_ptr_r;
      end
      if (drop_s) begin
        discard_nxt_s = discard_r - ONE_C;
      end else begin
        discard_nxt_s = discard_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PONE_C;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + ONE_C;
        2'b01:   count_nxt_s = count_r - ONE_C;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= ZERO_C;
      discard_r     <= ZERO_C;
      count_r       <= ZERO_C;
      rd_ptr_r      <= PZERO_C;
      wr_ptr_r      <= PZERO_C;
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      resp_pc_r     <= resp_pc_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= discard_nxt_s;
      count_r       <= count_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
    end
  end

  // Prefetch storage write port: {address, word} of each accepted response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem_r[i] <= 32'h0000_0000;
        data_mem_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      addr_mem_r[wr_ptr_r] <= resp_pc_r;
      data_mem_r[wr_ptr_r] <= bus.imem_rdata_i;
    end
  end

  // Drive memory request and decode-side outputs; NOP/0 when nothing valid
  always_comb begin
    bus.imem_req_o   = req_s;
    bus.imem_addr_o  = fetch_pc_r;
    bus.inst_valid_o = valid_s;
    if (valid_s) begin
      bus.inst_o      = data_mem_r[rd_ptr_r];
      bus.inst_addr_o = addr_mem_r[rd_ptr_r];
    end else begin
      bus.inst_o      = NOP_INST;
      bus.inst_addr_o = 32'h0000_0000;
    end
  end

  if_fetch_chk #(.FIFO_DEPTH(FIFO_DEPTH)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .count (count_r)
  );
endmodule

// Invariant checker: the credit rule must make a push into a full FIFO impossible.
module if_fetch_chk #(
  parameter int FIFO_DEPTH = 2
) (
  input logic                          clk,
  input logic                          rst,
  input logic                          push,
  input logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == CW'(FIFO_DEPTH))));
endmodule
